// File: rtl/pipelined_exec_alu.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops with a registered result,
// plus an iterative shift-add multiplier with Busy/Done handshaking for stall control.
module pipelined_exec_alu #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [5:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Shamt,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_MUL = 6'b011000;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SLL = 6'b000000;
    localparam logic [5:0] OP_SRL = 6'b000010;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        MUL_RUN
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_step;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] single_res;
    logic             load_mul, issue_single, finish_mul;

    always_comb begin
        single_res = '0;
        case (ALUControl)
            OP_ADD:  single_res = A + B;
            OP_SUB:  single_res = A - B;
            OP_AND:  single_res = A & B;
            OP_OR:   single_res = A | B;
            OP_NOR:  single_res = ~(A | B);
            OP_XOR:  single_res = A ^ B;
            OP_SLL:  single_res = B << Shamt;
            OP_SRL:  single_res = B >> Shamt;
            default: single_res = '0;
        endcase
    end

    // The final iteration's partial sum is folded in combinationally so Result
    // is written on the same edge that completes iteration WIDTH.
    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge Clk) begin
        if (!Rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next   = state;
        load_mul     = 1'b0;
        issue_single = 1'b0;
        finish_mul   = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (ALUControl == OP_MUL) begin
                        load_mul   = 1'b1;
                        state_next = MUL_RUN;
                    end else begin
                        issue_single = 1'b1;
                    end
                end
            end
            MUL_RUN: begin
                if (count == LAST) begin
                    finish_mul = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            Result <= '0;
            Zero   <= 1'b1;
            Done   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            Done <= issue_single | finish_mul;
            if (issue_single) begin
                Result <= single_res;
                Zero   <= (single_res == '0);
            end
            if (load_mul) begin
                mcand  <= A;
                mplier <= B;
                acc    <= '0;
                count  <= '0;
            end else if (state == MUL_RUN) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
            end
            if (finish_mul) begin
                Result <= acc_step;
                Zero   <= (acc_step == '0);
            end
        end
    end

    assign Busy = (state == MUL_RUN);

endmodule

// File: tb/tb_pipelined_exec_alu.sv
// Scoreboard bench for pipelined_exec_alu: expected results queued at issue,
// compared whenever Done is observed.
module tb_pipelined_exec_alu;

    localparam int WIDTH = 32;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_MUL = 6'b011000;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SLL = 6'b000000;
    localparam logic [5:0] OP_SRL = 6'b000010;

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic             Start = 1'b0;
    logic [5:0]       ALUControl = '0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic [4:0]       Shamt = '0;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Busy;
    logic             Done;

    int vectors = 0;
    int miscompares = 0;
    logic [WIDTH-1:0] expq[$];
    logic [WIDTH-1:0] last_result = '0;

    pipelined_exec_alu #(.WIDTH(WIDTH)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .ALUControl(ALUControl),
        .A(A), .B(B), .Shamt(Shamt),
        .Result(Result), .Zero(Zero), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [5:0] ctl, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b, input logic [4:0] sh);
        logic [WIDTH-1:0] r;
        case (ctl)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = b << sh;
            OP_SRL:  r = b >> sh;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Advance one clock, then sample; any Done pops and checks the scoreboard.
    task automatic step();
        logic [WIDTH-1:0] e;
        @(posedge Clk);
        #1;
        if (Done) begin
            if (expq.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = expq.pop_front();
                check("result", Result, e);
                check("zero", Zero, (e == '0));
                last_result = e;
            end
        end
    endtask

    task automatic drive(input logic [5:0] ctl, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [4:0] sh);
        ALUControl = ctl;
        A = a;
        B = b;
        Shamt = sh;
        Start = 1'b1;
        expq.push_back(model(ctl, a, b, sh));
        step();
    endtask

    task automatic issue(input string tag, input logic [5:0] ctl, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [4:0] sh);
        drive(ctl, a, b, sh);
        check({tag, "_done"}, Done, 1);
    endtask

    task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit interfere);
        int busy_cycles;
        bit seen;
        logic [WIDTH-1:0] prev;
        prev = last_result;
        busy_cycles = 0;
        seen = 0;
        drive(OP_MUL, a, b, 5'd0);
        check("mul_hold_result", Result, prev);
        check("mul_no_early_done", Done, 0);
        for (int i = 0; i < 40; i++) begin
            if (Done) begin
                seen = 1;
                break;
            end
            if (Busy) busy_cycles++;
            if (interfere && i == 5) begin
                Start = 1'b1;
                ALUControl = OP_ADD;
                A = $urandom;
                B = $urandom;
            end else begin
                Start = 1'b0;
                if (interfere) begin
                    A = $urandom;
                    B = $urandom;
                end
            end
            step();
        end
        Start = 1'b0;
        check("mul_done_seen", seen, 1);
        check("mul_busy_cycles", busy_cycles, WIDTH);
        check("mul_busy_clear", Busy, 0);
        step();
        check("mul_single_done", Done, 0);
    endtask

    initial begin
        // Reset held with a MUL start applied
        Rst = 1'b0;
        Start = 1'b1;
        ALUControl = OP_MUL;
        A = 32'h1234_5678;
        B = 32'h0000_0003;
        step();
        step();
        check("rst_result", Result, 0);
        check("rst_zero", Zero, 1);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        Rst = 1'b1;
        Start = 1'b0;
        step();
        check("post_rst_busy", Busy, 0);
        check("post_rst_done", Done, 0);

        // Back-to-back single-cycle ops
        issue("add", OP_ADD, 32'h5, 32'h3, 5'd0);
        check("add_val", Result, 32'h8);
        issue("sub_neg", OP_SUB, 32'h3, 32'h5, 5'd0);
        check("sub_neg_val", Result, 32'hFFFF_FFFE);
        issue("sub_zero", OP_SUB, 32'h7, 32'h7, 5'd0);
        check("sub_zero_flag", Zero, 1);
        issue("nor", OP_NOR, 32'h0, 32'h0, 5'd0);
        check("nor_val", Result, 32'hFFFF_FFFF);
        issue("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
        issue("or", OP_OR, 32'hF0F0_0000, 32'h0000_00FF, 5'd0);
        issue("xor", OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0);
        issue("undef", 6'b111111, 32'h1, 32'h2, 5'd0);
        check("undef_zero", Zero, 1);

        // Shifts
        issue("sll31", OP_SLL, 32'h0, 32'h1, 5'd31);
        check("sll31_val", Result, 32'h8000_0000);
        issue("srl4", OP_SRL, 32'h0, 32'h8000_0000, 5'd4);
        check("srl4_val", Result, 32'h0800_0000);
        issue("sll0", OP_SLL, 32'h0, 32'hDEAD_BEEF, 5'd0);
        check("sll0_val", Result, 32'hDEAD_BEEF);
        issue("srl0", OP_SRL, 32'h0, 32'h1357_9BDF, 5'd0);
        Start = 1'b0;
        step();
        check("idle_done_low", Done, 0);
        check("idle_hold", Result, 32'h1357_9BDF);

        // Multiplier
        run_mul(32'hFFFF_FFFF, 32'h0000_0007, 1'b0);
        check("mul_neg_val", Result, 32'hFFFF_FFF9);
        run_mul(32'h0001_0000, 32'h0001_0000, 1'b0);
        check("mul_zero_flag", Zero, 1);
        run_mul(32'h1234_5678, 32'h9ABC_DEF1, 1'b1);
        run_mul(32'hCAFE_F00D, 32'h8765_4321, 1'b0);

        // Reset mid-multiply aborts without Done
        ALUControl = OP_MUL;
        A = 32'h0000_00FF;
        B = 32'h0000_0101;
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("midmul_busy", Busy, 1);
        Rst = 1'b0;
        step();
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_result", Result, 0);
        check("abort_zero", Zero, 1);
        Rst = 1'b1;
        for (int i = 0; i < 35; i++) begin
            step();
            if (Done) break;
        end
        check("abort_no_done", Done, 0);
        check("abort_result_hold", Result, 0);
        issue("add_after_abort", OP_ADD, 32'h0000_1000, 32'h0000_0234, 5'd0);
        check("add_after_abort_val", Result, 32'h0000_1234);
        Start = 1'b0;
        step();

        check("queue_empty", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
